// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg
//  Shared types and helpers for the FIFO word packer.
//  - acc_state_t : occupancy of the packing accumulator.
//  - cnt_width() : bits needed to hold a lane count 0..P inclusive.

package fifo_pack_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } acc_state_t;

   // A count must reach P itself (a full beat), hence P+1 codes.
   function automatic int cnt_width(input int p);
      return $clog2(p + 1);
   endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// pack_idle_timer
//  Saturating idle counter used to force out a partial beat that has been
//  sitting in the accumulator too long.
// Ports
//  clk_i      in  clock, rising edge
//  rst_i      in  asynchronous active-high reset
//  clr_i      in  synchronous clear (wins over en_i)
//  en_i       in  count one idle cycle
//  expired_o  out counter has reached TIMEOUT_CYCLES (0 forever when disabled)

module pack_idle_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

   if (TIMEOUT_CYCLES > 0) begin : g_timer
      logic [TW-1:0] timer_q;
      logic [TW-1:0] timer_d;

      always_comb begin
         timer_d = timer_q;
         if (clr_i) begin
            timer_d = '0;
         end else if (en_i && (timer_q != LIMIT)) begin
            timer_d = timer_q + 1'b1;
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_d;
         end
      end

      assign expired_o = (timer_q == LIMIT);
   end else begin : g_no_timer
      assign expired_o = 1'b0;
   end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//  Pops narrow words from an FWFT FIFO and packs PACK_RATIO of them into one
//  wide beat presented on a valid/ready stream. A partial beat is emitted on
//  flush_i or after TIMEOUT_CYCLES idle cycles (0 disables the timeout).
// Ports
//  clk_i           in  clock, rising edge
//  rst_i           in  asynchronous active-high reset
//  fifo_empty_i    in  FIFO empty flag
//  fifo_rd_data_i  in  FIFO head word, valid while !fifo_empty_i
//  fifo_read_o     out pop request (combinational)
//  flush_i         in  emit the current partial beat
//  pkt_data_o      out packed beat, lane 0 (LSBs) = oldest word, unused lanes 0
//  pkt_words_o     out number of valid lanes (1..PACK_RATIO)
//  pkt_valid_o     out beat valid
//  pkt_ready_i     in  consumer accepts the beat

module fifo_word_packer
   import fifo_pack_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PACK_RATIO     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]            fifo_rd_data_i,
   output logic                             fifo_read_o,
   input  logic                             flush_i,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] pkt_data_o,
   output logic [cnt_width(PACK_RATIO)-1:0] pkt_words_o,
   output logic                             pkt_valid_o,
   input  logic                             pkt_ready_i
);

   localparam int CW = cnt_width(PACK_RATIO);
   localparam int BW = DATA_WIDTH * PACK_RATIO;
   localparam logic [CW-1:0] CNT_FULL = CW'(PACK_RATIO);

   acc_state_t    acc_state_q, acc_state_d;
   logic [BW-1:0] acc_data_q,  acc_data_d;
   logic [CW-1:0] acc_cnt_q,   acc_cnt_d;
   logic          pend_q,      pend_d;
   logic [BW-1:0] pkt_data_q,  pkt_data_d;
   logic [CW-1:0] pkt_words_q, pkt_words_d;
   logic          pkt_valid_q, pkt_valid_d;

   logic          pop;
   logic [BW-1:0] merged_data;
   logic [CW-1:0] merged_cnt;
   logic          have_data;
   logic          out_free;
   logic          flush_trig;
   logic          xfer;
   logic          timer_expired;

   // No pops while the accumulator is full, and none at all during reset.
   assign pop = !rst_i && !fifo_empty_i && (acc_state_q != FULL);
   assign fifo_read_o = pop;

   // Accumulator contents as they would be after this edge's pop: the word
   // popped this cycle goes into lane acc_cnt, so a transfer in the same edge
   // carries it along.
   for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
      assign merged_data[gi*DATA_WIDTH +: DATA_WIDTH] =
         (pop && (acc_cnt_q == CW'(gi))) ? fifo_rd_data_i
                                         : acc_data_q[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   assign merged_cnt = acc_cnt_q + {{(CW-1){1'b0}}, pop};
   assign have_data  = (merged_cnt != '0);
   assign out_free   = !pkt_valid_q || pkt_ready_i;

   // A flush with nothing to send (no stored word, no pop) is dropped so that
   // zero-length beats never appear.
   assign flush_trig = (flush_i || timer_expired) && have_data;

   assign xfer = out_free &&
                 ((merged_cnt == CNT_FULL) || ((pend_q || flush_trig) && have_data));

   always_comb begin
      acc_data_d  = acc_data_q;
      acc_cnt_d   = acc_cnt_q;
      pend_d      = pend_q;
      pkt_data_d  = pkt_data_q;
      pkt_words_d = pkt_words_q;
      pkt_valid_d = pkt_valid_q;

      if (xfer) begin
         // Lanes above merged_cnt are zero because the accumulator is cleared
         // after every transfer, so the beat needs no extra masking.
         pkt_data_d  = merged_data;
         pkt_words_d = merged_cnt;
         pkt_valid_d = 1'b1;
         acc_data_d  = '0;
         acc_cnt_d   = '0;
         pend_d      = 1'b0;
      end else begin
         acc_data_d = merged_data;
         acc_cnt_d  = merged_cnt;
         pend_d     = pend_q || flush_trig;
         if (out_free) begin
            pkt_valid_d = 1'b0;
         end
      end

      if (acc_cnt_d == '0) begin
         acc_state_d = EMPTY;
      end else if (acc_cnt_d == CNT_FULL) begin
         acc_state_d = FULL;
      end else begin
         acc_state_d = PARTIAL;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_state_q <= EMPTY;
         acc_data_q  <= '0;
         acc_cnt_q   <= '0;
         pend_q      <= 1'b0;
         pkt_data_q  <= '0;
         pkt_words_q <= '0;
         pkt_valid_q <= 1'b0;
      end else begin
         acc_state_q <= acc_state_d;
         acc_data_q  <= acc_data_d;
         acc_cnt_q   <= acc_cnt_d;
         pend_q      <= pend_d;
         pkt_data_q  <= pkt_data_d;
         pkt_words_q <= pkt_words_d;
         pkt_valid_q <= pkt_valid_d;
      end
   end

   // Idle time only accrues while a partial beat waits with no new word.
   pack_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (pop || xfer),
      .en_i      ((acc_state_q == PARTIAL) && !pop),
      .expired_o (timer_expired)
   );

   assign pkt_data_o  = pkt_data_q;
   assign pkt_words_o = pkt_words_q;
   assign pkt_valid_o = pkt_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

   localparam int DW = 8;
   localparam int P  = 4;
   localparam int TO = 8;
   localparam int CW = $clog2(P + 1);

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            fifo_empty_i;
   logic [DW-1:0]   fifo_rd_data_i;
   logic            fifo_read_o;
   logic            flush_i;
   logic [DW*P-1:0] pkt_data_o;
   logic [CW-1:0]   pkt_words_o;
   logic            pkt_valid_o;
   logic            pkt_ready_i;

   always #5 clk_i = ~clk_i;

   fifo_word_packer #(
      .DATA_WIDTH     (DW),
      .PACK_RATIO     (P),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .fifo_empty_i   (fifo_empty_i),
      .fifo_rd_data_i (fifo_rd_data_i),
      .fifo_read_o    (fifo_read_o),
      .flush_i        (flush_i),
      .pkt_data_o     (pkt_data_o),
      .pkt_words_o    (pkt_words_o),
      .pkt_valid_o    (pkt_valid_o),
      .pkt_ready_i    (pkt_ready_i)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Bench-side FWFT FIFO
   logic [DW-1:0] fifo_q[$];
   logic          gate_empty = 1'b0;

   task automatic drive_pins();
      fifo_empty_i   = gate_empty || (fifo_q.size() == 0);
      fifo_rd_data_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   // Reference model: words waiting to be packed, the visible beat, a pending
   // flush flag and the number of idle cycles spent with a partial beat.
   logic [DW-1:0]   m_acc[$];
   bit              m_pend;
   int              m_idle;
   bit              m_valid;
   logic [DW*P-1:0] m_data;
   int              m_words;

   // Observed DUT traffic, for the directed expectations.
   int              valid_cycles;
   int              acc_beats;
   logic [DW*P-1:0] last_data;
   int              last_words;

   task automatic model_reset();
      m_acc.delete();
      m_pend  = 0;
      m_idle  = 0;
      m_valid = 0;
      m_data  = '0;
      m_words = 0;
   endtask

   // One clock cycle: compare at the falling edge, predict, pass the rising
   // edge, update the model and the bench FIFO. Called at posedge+1.
   task automatic cycle();
      bit            pop, trig, free, xfer;
      logic [DW-1:0] w[$];
      int            n;
      @(negedge clk_i);
      pop = !fifo_empty_i && (m_acc.size() < P);
      check_eq("fifo_read", fifo_read_o, pop);
      check_eq("pkt_valid", pkt_valid_o, m_valid);
      if (m_valid) begin
         check_eq("pkt_data", pkt_data_o, m_data);
         check_eq("pkt_words", pkt_words_o, m_words);
      end
      if (pkt_valid_o) begin
         valid_cycles++;
         if (pkt_ready_i) begin
            acc_beats++;
            last_data  = pkt_data_o;
            last_words = int'(pkt_words_o);
         end
      end
      w = m_acc;
      if (pop) w.push_back(fifo_rd_data_i);
      n    = w.size();
      trig = (flush_i || (TO != 0 && m_idle == TO)) && (n > 0);
      free = !m_valid || pkt_ready_i;
      xfer = free && ((n == P) || ((m_pend || trig) && n > 0));
      @(posedge clk_i);
      #1;
      if (xfer) begin
         m_data = '0;
         foreach (w[i]) m_data[i*DW +: DW] = w[i];
         m_words = n;
         m_valid = 1;
         m_acc.delete();
         m_pend = 0;
         m_idle = 0;
      end else begin
         if (pop) m_idle = 0;
         else if (m_acc.size() > 0 && m_acc.size() < P && m_idle < TO) m_idle++;
         m_acc  = w;
         m_pend = m_pend || trig;
         if (free) m_valid = 0;
      end
      if (pop) void'(fifo_q.pop_front());
      drive_pins();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic push(input logic [DW-1:0] v);
      fifo_q.push_back(v);
      drive_pins();
   endtask

   initial begin
      int b0, n;

      rst_i       = 1'b1;
      flush_i     = 1'b0;
      pkt_ready_i = 1'b0;
      drive_pins();
      model_reset();
      valid_cycles = 0;
      acc_beats    = 0;
      last_data    = '0;
      last_words   = 0;
      #1;
      check_eq("rst_valid", pkt_valid_o, 0);
      check_eq("rst_data", pkt_data_o, 0);
      check_eq("rst_words", pkt_words_o, 0);
      check_eq("rst_read", fifo_read_o, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // 1: four words, ready high -> one full beat for one cycle
      pkt_ready_i = 1'b1;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      b0 = acc_beats; valid_cycles = 0;
      run(6);
      check_eq("t1_beats", acc_beats - b0, 1);
      check_eq("t1_data", last_data, 32'h44332211);
      check_eq("t1_words", last_words, 4);
      check_eq("t1_valid_cycles", valid_cycles, 1);

      // 2: ready low, eight words -> first beat held, second fills accumulator
      pkt_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) push(8'h55 + 8'(i * 8'h11));
      run(10);
      check_eq("t2_hold_valid", pkt_valid_o, 1);
      check_eq("t2_hold_data", pkt_data_o, 32'h88776655);
      check_eq("t2_hold_words", pkt_words_o, 4);
      pkt_ready_i = 1'b1;
      cycle();
      check_eq("t2_next_valid", pkt_valid_o, 1);
      check_eq("t2_next_data", pkt_data_o, 32'hCCBBAA99);
      cycle();
      check_eq("t2_drained", pkt_valid_o, 0);

      // 3: three words then a flush pulse
      push(8'hA1); push(8'hA2); push(8'hA3);
      run(3);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      check_eq("t3_data", pkt_data_o, 32'h00A3A2A1);
      check_eq("t3_words", pkt_words_o, 3);
      run(2);

      // 4: two words then idle -> timeout flush
      push(8'h01); push(8'h02);
      run(2);
      n = 0;
      for (int k = 0; k < 20 && !pkt_valid_o; k++) begin
         cycle();
         n++;
      end
      check_eq("t4_valid", pkt_valid_o, 1);
      check_eq("t4_idle_edges", n, TO + 1);
      check_eq("t4_data", pkt_data_o, 32'h00000201);
      check_eq("t4_words", pkt_words_o, 2);
      run(2);

      // 5a: flush with empty accumulator -> nothing
      b0 = acc_beats; valid_cycles = 0;
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      run(3);
      check_eq("t5_no_beat", valid_cycles, 0);
      // 5b: flush together with the completing pop -> exactly one beat
      push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
      run(3);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      run(4);
      check_eq("t5_one_beat", acc_beats - b0, 1);
      check_eq("t5_words", last_words, 4);
      check_eq("t5_data", last_data, 32'hD4D3D2D1);

      // 6: reset while a beat is held
      pkt_ready_i = 1'b0;
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      run(5);
      check_eq("t6_held", pkt_valid_o, 1);
      push(8'h77);
      #2 rst_i = 1'b1;
      #1;
      check_eq("t6_rst_valid", pkt_valid_o, 0);
      check_eq("t6_rst_read", fifo_read_o, 0);
      check_eq("t6_rst_words", pkt_words_o, 0);
      model_reset();
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      cycle();
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      check_eq("t6_lane0_data", pkt_data_o, 32'h00000077);
      check_eq("t6_lane0_words", pkt_words_o, 1);
      pkt_ready_i = 1'b1;
      run(2);

      // Randomised traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
         pkt_ready_i = ($urandom_range(0, 3) != 0);
         flush_i     = ($urandom_range(0, 15) == 0);
         gate_empty  = ($urandom_range(0, 4) == 0);
         drive_pins();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
